// File: rtl/ysyx_22040759_scoreboard_pkg.sv
// Shared constants for the register-write scoreboard.
package ysyx_22040759_scoreboard_pkg;
    localparam int NREG = 32;
    localparam int CNT_W = 2;
    localparam int RIDX_W = 5;
    localparam logic [RIDX_W-1:0] REG_X0 = 5'd0;
endpackage

// File: rtl/ysyx_22040759_sb_cnt.sv
// One pending-write counter: saturating up/down with synchronous clear.
module ysyx_22040759_sb_cnt
    import ysyx_22040759_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             at_max
);

    assign nz     = |cnt;
    assign at_max = &cnt;

    // inc and dec together cancel; dec at zero is absorbed here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && nz) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040759_scoreboard.sv
// Per-register pending-write scoreboard beside ID; drives the issue stall.
module ysyx_22040759_scoreboard
    import ysyx_22040759_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wen,
    input  logic [RIDX_W-1:0] issue_rd,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              flush_all,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec,
    output logic              err_underflow
);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  nz;
    logic [NREG-1:0]  at_max;
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;
    logic [NREG-1:0]  eff_nz;
    logic             hz1;
    logic             hz2;
    logic             sat;
    logic             stall_raw;
    logic             fire;
    logic             under;

    assign cnt[0]    = '0;
    assign nz[0]     = 1'b0;
    assign at_max[0] = 1'b0;
    assign inc[0]    = 1'b0;
    assign dec[0]    = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign inc[r] = fire && (issue_rd == RIDX_W'(r));
        assign dec[r] = wb_valid && (wb_rd == RIDX_W'(r));

        ysyx_22040759_sb_cnt u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc[r]),
            .dec    (dec[r]),
            .clr    (flush_all),
            .cnt    (cnt[r]),
            .nz     (nz[r]),
            .at_max (at_max[r])
        );
    end

    // A retire this cycle is visible to readers thanks to write-through
    for (genvar r = 0; r < NREG; r++) begin : g_eff
        assign eff_nz[r] = nz[r] && !(dec[r] && cnt[r] == CNT_W'(1));
    end

    assign hz1 = rs1_used && (rs1 != REG_X0) && eff_nz[rs1];
    assign hz2 = rs2_used && (rs2 != REG_X0) && eff_nz[rs2];
    assign sat = issue_wen && (issue_rd != REG_X0) && at_max[issue_rd];

    assign stall_raw = issue_valid && (hz1 || hz2 || sat);
    assign stall     = stall_raw && !rst;
    assign fire      = issue_valid && !stall_raw && issue_wen
                       && (issue_rd != REG_X0);

    assign busy_vec = nz & {NREG{!rst}};

    // Flush discards the retire, and a matching fire cancels it
    assign under = wb_valid && (wb_rd != REG_X0) && !flush_all
                   && !nz[wb_rd] && !(fire && issue_rd == wb_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (under) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_scoreboard.sv
// Vector-table bench for the write scoreboard with an expectation queue.
module tb_ysyx_22040759_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_wen;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush_all;
    logic        stall;
    logic [31:0] busy_vec;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        iv;
        logic        wen;
        logic [4:0]  rd;
        logic [4:0]  s1;
        logic        u1;
        logic [4:0]  s2;
        logic        u2;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        st;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    typedef struct {
        logic        st;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    ysyx_22040759_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_wen     (issue_wen),
        .issue_rd      (issue_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush_all     (flush_all),
        .stall         (stall),
        .busy_vec      (busy_vec),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] b(input int r);
        logic [31:0] m;
        m = 32'd1 << r;
        return m;
    endfunction

    function automatic vec_t mk(
        input logic iv, input logic wen, input logic [4:0] rd,
        input logic [4:0] s1, input logic u1,
        input logic [4:0] s2, input logic u2,
        input logic wv, input logic [4:0] wrd, input logic fl,
        input logic st, input logic [31:0] busy, input logic err);
        vec_t v;
        v.iv = iv; v.wen = wen; v.rd = rd;
        v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
        v.wv = wv; v.wrd = wrd; v.fl = fl;
        v.st = st; v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv;
        issue_wen   = v.wen;
        issue_rd    = v.rd;
        rs1         = v.s1;
        rs1_used    = v.u1;
        rs2         = v.s2;
        rs2_used    = v.u2;
        wb_valid    = v.wv;
        wb_rd       = v.wrd;
        flush_all   = v.fl;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back('{v.st, v.busy, v.err});
        #1;
        e = exp_q[0];
        chk($sformatf("stall[%0d]", idx), {31'd0, stall}, {31'd0, e.st});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("busy[%0d]", idx), busy_vec, e.busy);
        chk($sformatf("err[%0d]", idx), {31'd0, err_underflow},
            {31'd0, e.err});
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(idle);
        #1;
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, err_underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // load-use on x5, released by a same-cycle retire
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, b(5), 0));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, b(5), 0));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, b(5), 0));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, b(5), 0));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // same-cycle issue and retire on x7
        vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, b(7), 0));
        vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0, b(7), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        // saturation on x9
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, b(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, b(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, b(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, b(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 1, 9, 0, 1, b(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, b(9), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, b(9), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, b(9), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
        // x0 ignored, then a real underflow on x12
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1));
        // flush with a same-cycle issue
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, b(3), 1));
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 3, 1, 4, 1, 0, 0, 0, 0, 0, 1));
        // rs2 port hazard and its used gate
        vecs.push_back(mk(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, b(10), 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 1, b(10), 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 10, 0, 0, 0, 0, 0, b(10), 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1));
        // two writes pending on x5 for the reset check
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, b(5), 1));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, b(5), 1));

        foreach (vecs[i]) apply(vecs[i], i);

        // async reset mid-operation
        @(negedge clk);
        drive(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", busy_vec, 32'd0);
        chk("async_stall", {31'd0, stall}, 32'd0);
        chk("async_err", {31'd0, err_underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_busy", busy_vec, 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
